// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal shift register. One bank of flops covers hold,
// serial shift right/left, rotate right/left, parallel load and clear, so the
// same block serves SISO, SIPO, PISO and PIPO roles. A shift counter tracks
// progress through a WIDTH-bit frame and raises a registered one-cycle
// frame_done pulse when the WIDTH-th shift completes.
//
// Parameters:
//   WIDTH      register width in bits (2..64)
//   RESET_VAL  value loaded into q on reset
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low (overrides en and mode)
//   en         operation enable; 0 freezes q and cnt
//   mode       operation select (see mode_e below)
//   sin_r      serial input for shift right, enters at q[WIDTH-1]
//   sin_l      serial input for shift left, enters at q[0]
//   pdata      parallel load data
//   q          register contents
//   sout_r     serial out for right shift (q[0])
//   sout_l     serial out for left shift (q[WIDTH-1])
//   cnt        shifts since the last load, clear, reset or frame wrap
//   frame_done one-cycle pulse after the WIDTH-th shift of a frame
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] qNext;
  logic [CW-1:0]    cntNext;
  logic             frameNext;
  logic             isShift;
  logic             lastShift;

  assign op = mode_e'(mode);

  // Serial taps come straight off the register so they follow q in the same
  // cycle it updates.
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  // The counter wraps on the shift that would take it to WIDTH, which is
  // exactly the shift that completes a frame.
  assign lastShift = (cnt == CW'(WIDTH - 1));

  // Next-state data path. The reserved encoding falls into the default arm
  // and behaves as hold. Everything defaults to "no change" so that en=0
  // leaves the register and counter untouched.
  always_comb begin
    qNext   = q;
    isShift = 1'b0;
    if (en) begin
      case (op)
        MODE_SHR: begin
          qNext   = {sin_r, q[WIDTH-1:1]};
          isShift = 1'b1;
        end
        MODE_SHL: begin
          qNext   = {q[WIDTH-2:0], sin_l};
          isShift = 1'b1;
        end
        MODE_LOAD:  qNext = pdata;
        MODE_ROTR: begin
          qNext   = {q[0], q[WIDTH-1:1]};
          isShift = 1'b1;
        end
        MODE_ROTL: begin
          qNext   = {q[WIDTH-2:0], q[WIDTH-1]};
          isShift = 1'b1;
        end
        MODE_CLEAR: qNext = '0;
        default:    qNext = q;
      endcase
    end
  end

  // Frame counter. Shifts in either direction advance it; load and clear
  // restart the frame; anything else freezes it. frame_done is only ever set
  // by the wrapping shift, so it drops again on the following cycle unless
  // another wrap happens.
  always_comb begin
    cntNext   = cnt;
    frameNext = 1'b0;
    if (en) begin
      if (isShift) begin
        if (lastShift) begin
          cntNext   = '0;
          frameNext = 1'b1;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end else if (op == MODE_LOAD || op == MODE_CLEAR) begin
        cntNext = '0;
      end
    end
  end

  // State register with synchronous active-low reset, which wins over en and
  // mode and discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q          <= RESET_VAL;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      q          <= qNext;
      cnt        <= cntNext;
      frame_done <= frameNext;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5). The
// stimulus thread drives one operation per clock, advances a behavioural
// model and pushes the expected post-edge state into a scoreboard queue. A
// separate monitor pops one entry after every rising edge and compares it to
// the DUT. Directed scenarios add a few hand-derived constant checks.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int             W    = 8;
  localparam int             CW   = $clog2(W + 1);
  localparam logic [W-1:0]   RVAL = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic          sin_r;
  logic          sin_l;
  logic [W-1:0]  pdata;
  logic [W-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] cnt;
  logic          frame_done;

  typedef struct {
    logic [W-1:0] q;
    int           cnt;
    logic         fd;
  } exp_t;

  exp_t         sbQ[$];
  int           checks = 0;
  int           errors = 0;

  // Behavioural model: register value plus a count of shifts in the current
  // frame; frame position and frame completion come from modular arithmetic.
  logic [W-1:0] mq;
  int           shifts;
  logic         mfd;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .pdata(pdata), .q(q), .sout_r(sout_r),
    .sout_l(sout_l), .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Generic comparison used by both the monitor and the directed checks.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Called at a negative edge: drive inputs, update the model, enqueue the
  // expected state, then wait until the following negative edge.
  task automatic applyStimulus(input logic r, input logic e,
                               input logic [2:0] m, input logic sr,
                               input logic sl, input logic [W-1:0] pd);
    bit shiftOp;
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
    shiftOp = 0;
    mfd = 0;
    if (!r) begin
      mq = RVAL;
      shifts = 0;
    end else if (e) begin
      case (m)
        3'd1: begin mq = (mq >> 1) | (W'(sr) << (W - 1)); shiftOp = 1; end
        3'd2: begin mq = (mq << 1) | W'(sl); shiftOp = 1; end
        3'd3: begin mq = pd; shifts = 0; end
        3'd4: begin mq = (mq >> 1) | (mq << (W - 1)); shiftOp = 1; end
        3'd5: begin mq = (mq << 1) | (mq >> (W - 1)); shiftOp = 1; end
        3'd6: begin mq = '0; shifts = 0; end
        default: ;
      endcase
      if (shiftOp) begin
        shifts++;
        mfd = (shifts % W == 0);
        shifts = shifts % W;
      end
    end
    sbQ.push_back('{q: mq, cnt: shifts, fd: mfd});
    @(negedge clk);
  endtask

  // Monitor: every rising edge produces a new state; compare it 1ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("q",          64'(q),          64'(e.q));
        checkOutput("cnt",        64'(cnt),        64'(e.cnt));
        checkOutput("frame_done", 64'(frame_done), 64'(e.fd));
        checkOutput("sout_r",     64'(sout_r),     64'(e.q & 1));
        checkOutput("sout_l",     64'(sout_l),     64'(e.q >> (W - 1)));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] sipoBits;
    logic [7:0] pisoExp;
    rst = 1'b1; en = 1'b0; mode = 3'd0; sin_r = 1'b0; sin_l = 1'b0;
    pdata = '0; mq = '0; shifts = 0; mfd = 0;
    @(negedge clk);

    $display("[TB] reset with load requested");
    applyStimulus(0, 1, 3'd3, 0, 0, 8'hFF);
    applyStimulus(0, 1, 3'd3, 0, 0, 8'hFF);
    checkOutput("reset_q", 64'(q), 64'h A5);
    checkOutput("reset_cnt", 64'(cnt), 64'd0);

    $display("[TB] SIPO shift right");
    sipoBits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 3'd1, sipoBits[i], 0, 8'h00);
      checkOutput("sipo_cnt", 64'(cnt), 64'((i + 1) % 8));
      checkOutput("sipo_fd", 64'(frame_done), 64'(i == 7));
    end
    checkOutput("sipo_q", 64'(q), 64'h4D);
    applyStimulus(1, 1, 3'd0, 0, 0, 8'h00);
    checkOutput("sipo_fd_drop", 64'(frame_done), 64'd0);

    $display("[TB] PISO shift left");
    applyStimulus(1, 1, 3'd3, 0, 0, 8'h81);
    checkOutput("piso_load_cnt", 64'(cnt), 64'd0);
    pisoExp = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      checkOutput("piso_sout_l", 64'(sout_l), 64'(pisoExp[7 - i]));
      applyStimulus(1, 1, 3'd2, 0, 0, 8'h00);
    end
    checkOutput("piso_q", 64'(q), 64'h00);
    checkOutput("piso_fd", 64'(frame_done), 64'd1);

    $display("[TB] rotate and enable");
    applyStimulus(1, 1, 3'd3, 0, 0, 8'h01);
    repeat (3) applyStimulus(1, 1, 3'd5, 0, 0, 8'h00);
    checkOutput("rotl_q", 64'(q), 64'h08);
    applyStimulus(1, 1, 3'd4, 0, 0, 8'h00);
    checkOutput("rotr_q", 64'(q), 64'h04);
    repeat (4) applyStimulus(1, 0, 3'd5, 1, 1, 8'hFF);
    checkOutput("en0_q", 64'(q), 64'h04);
    checkOutput("en0_cnt", 64'(cnt), 64'd4);

    $display("[TB] clear and reset mid-frame");
    repeat (5) applyStimulus(1, 1, 3'd1, 1, 0, 8'h00);
    applyStimulus(1, 1, 3'd6, 0, 0, 8'h00);
    checkOutput("clear_q", 64'(q), 64'h00);
    checkOutput("clear_cnt", 64'(cnt), 64'd0);
    repeat (5) applyStimulus(1, 1, 3'd2, 1, 1, 8'h00);
    applyStimulus(0, 1, 3'd2, 1, 1, 8'h00);
    checkOutput("midrst_q", 64'(q), 64'hA5);
    checkOutput("midrst_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 3'd4, 0, 0, 8'h00);
      checkOutput("postrst_fd", 64'(frame_done), 64'(i == 7));
    end

    $display("[TB] reserved mode and mixed directions");
    applyStimulus(1, 1, 3'd1, 0, 0, 8'h00);
    repeat (3) applyStimulus(1, 1, 3'd7, 1, 1, 8'hFF);
    checkOutput("rsvd_cnt", 64'(cnt), 64'd1);
    applyStimulus(1, 1, 3'd3, 0, 0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, (i < 3) ? 3'd1 : 3'd2, 1, 0, 8'h00);
      checkOutput("mixed_fd", 64'(frame_done), 64'(i == 7));
    end

    $display("[TB] randomized operations");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) != 0),
                    3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
